vx_pe_deserializer: RTL

Receive-side counterpart of the FPU lane-to-PE serializer: accepts per-PE result beats from a fixed-latency FPU core (NUM_PES results per beat) and reassembles them into one NUM_LANES-wide response with its tag, mask and merged exception flags. It sits between the FPU PE array output and the FPU response arbiter, providing a registered valid/ready response port with backpressure toward the PEs.

---
 rtl/vx_pe_deserializer_pkg.sv | 14 +
 rtl/vx_pe_deser_obuf.sv | 27 ++
 rtl/vx_pe_deserializer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vx_pe_deserializer_pkg.sv
// Shared FPU definitions: exception flag layout used by the PE result deserializer.
package VX_fpu_pkg;

   localparam int FP_FLAGS_BITS = 5;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

endpackage

// File: rtl/vx_pe_deser_obuf.sv
// Single-entry output register with valid/ready handshake; load may coincide with the
// outgoing handshake so back-to-back responses flow without a bubble.
module vx_pe_deser_obuf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ready_out,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out <= 1'b0;
         data_out  <= '0;
      end else if (load) begin
         valid_out <= 1'b1;
         data_out  <= data_in;
      end else if (ready_out) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: rtl/vx_pe_deserializer.sv
// Reassembles NUM_PES-wide FPU result beats into one NUM_LANES-wide response.
// Optional per-lane exception flag merging is enabled by defining VX_PE_DESER_FFLAGS_EN.
module vx_pe_deserializer
   import VX_fpu_pkg::*;
#(
   parameter int NUM_LANES  = 4,
   parameter int NUM_PES    = 1,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 1
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       pe_valid_in,
   output logic                                       pe_ready_in,
   input  logic [NUM_PES*(FP_FLAGS_BITS+DATA_WIDTH)-1:0] pe_data_in,
   input  logic [NUM_LANES-1:0]                       pe_mask_in,
   input  logic [TAG_WIDTH-1:0]                       pe_tag_in,
   output logic                                       valid_out,
   input  logic                                       ready_out,
   output logic [NUM_LANES*DATA_WIDTH-1:0]            result,
   output logic [NUM_LANES-1:0]                       mask_out,
   output logic [TAG_WIDTH-1:0]                       tag_out,
   output logic                                       has_fflags,
   output logic [FP_FLAGS_BITS-1:0]                   fflags
);

   localparam int NUM_BATCHES = (NUM_LANES + NUM_PES - 1) / NUM_PES;
   localparam int CNT_W       = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
   localparam int SLOT_W      = FP_FLAGS_BITS + DATA_WIDTH;
   localparam int OUT_W       = FP_FLAGS_BITS + TAG_WIDTH + NUM_LANES + NUM_LANES*DATA_WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BATCHES - 1);

   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] data_buf [NUM_LANES];
   logic [NUM_LANES-1:0]  mask_buf;
   logic [TAG_WIDTH-1:0]  tag_buf;
   logic [DATA_WIDTH-1:0] slot_data [NUM_PES];

   logic                           last_beat;
   logic                           beat_fire;
   logic [NUM_LANES*DATA_WIDTH-1:0] asm_result;
   logic [NUM_LANES-1:0]           asm_mask;
   logic [TAG_WIDTH-1:0]           asm_tag;
   logic [FP_FLAGS_BITS-1:0]       asm_fflags;
   logic [OUT_W-1:0]               obuf_out;

   assign last_beat   = (cnt == LAST_CNT);
   assign pe_ready_in = !reset && (!last_beat || !valid_out || ready_out);
   assign beat_fire   = pe_valid_in && pe_ready_in;

   always_comb begin
      for (int p = 0; p < NUM_PES; p++) begin
         slot_data[p] = pe_data_in[p*SLOT_W +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         mask_buf <= '0;
         tag_buf  <= '0;
      end else if (beat_fire) begin
         cnt <= last_beat ? '0 : cnt + CNT_W'(1);
         if (cnt == '0) begin
            mask_buf <= pe_mask_in;
            tag_buf  <= pe_tag_in;
         end
      end
   end

   // Lanes of the current beat come straight from the PEs; earlier lanes from the buffer.
   always_ff @(posedge clk) begin
      if (beat_fire && !last_beat) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (i / NUM_PES == int'(cnt)) data_buf[i] <= slot_data[i % NUM_PES];
         end
      end
   end

   always_comb begin
      asm_result = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (i / NUM_PES == int'(cnt)) asm_result[i*DATA_WIDTH +: DATA_WIDTH] = slot_data[i % NUM_PES];
         else                          asm_result[i*DATA_WIDTH +: DATA_WIDTH] = data_buf[i];
      end
      asm_mask = (cnt == '0) ? pe_mask_in : mask_buf;
      asm_tag  = (cnt == '0) ? pe_tag_in  : tag_buf;
   end

`ifdef VX_PE_DESER_FFLAGS_EN
   fflags_t slot_flags [NUM_PES];
   fflags_t flag_buf   [NUM_LANES];

   always_comb begin
      for (int p = 0; p < NUM_PES; p++) begin
         slot_flags[p] = fflags_t'(pe_data_in[p*SLOT_W + DATA_WIDTH +: FP_FLAGS_BITS]);
      end
   end

   always_ff @(posedge clk) begin
      if (beat_fire && !last_beat) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (i / NUM_PES == int'(cnt)) flag_buf[i] <= slot_flags[i % NUM_PES];
         end
      end
   end

   always_comb begin
      asm_fflags = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (asm_mask[i]) begin
            if (i / NUM_PES == int'(cnt)) asm_fflags = asm_fflags | slot_flags[i % NUM_PES];
            else                          asm_fflags = asm_fflags | flag_buf[i];
         end
      end
   end

   assign has_fflags = 1'b1;
`else
   logic unused_flag_bits;

   always_comb begin
      unused_flag_bits = 1'b0;
      for (int p = 0; p < NUM_PES; p++) begin
         unused_flag_bits = unused_flag_bits ^ (^pe_data_in[p*SLOT_W + DATA_WIDTH +: FP_FLAGS_BITS]);
      end
   end

   assign asm_fflags = '0;
   assign has_fflags = 1'b0;
`endif

   vx_pe_deser_obuf #(
      .WIDTH (OUT_W)
   ) u_obuf (
      .clk       (clk),
      .reset     (reset),
      .load      (beat_fire && last_beat),
      .data_in   ({asm_fflags, asm_tag, asm_mask, asm_result}),
      .ready_out (ready_out),
      .valid_out (valid_out),
      .data_out  (obuf_out)
   );

   assign {fflags, tag_out, mask_out, result} = obuf_out;

endmodule
